// File: rtl/memory_arbiter.sv
// Arbitrates icache and dcache requests onto a single RAM port.
// dcache has priority; a saturating starvation counter forces icache after STARVE_MAX dcache grants.
module memory_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [SW-1:0]   starve, next_starve;
  logic            dreq, access;

  assign dreq   = dREN | dWEN;
  assign access = (ramstate == RAM_ACCESS);
  assign iwait  = iREN & ~((state == IGRANT) & access);
  assign dwait  = dreq & ~((state == DGRANT) & access);

  // State and starvation counter registers
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      state  <= next_state;
      starve <= next_starve;
    end
  end

  // Next-state, starvation update and RAM/load steering
  always_comb begin
    next_state  = state;
    next_starve = starve;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iload       = '0;
    dload       = '0;
    case (state)
      IDLE: begin
        if (dreq && (!iREN || (starve < STARVE_TOP))) next_state = DGRANT;
        else if (iREN)                                 next_state = IGRANT;
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dload    = ramload;
        if (!dreq) begin
          next_state = IDLE;
        end else if (access) begin
          next_state = IDLE;
          if (iREN) next_starve = (starve == STARVE_TOP) ? starve : starve + SW'(1);
          else      next_starve = '0;
        end
      end
      IGRANT: begin
        // Read enable follows the request so a withdrawal drops it at once
        ramaddr = iaddr;
        ramREN  = iREN;
        iload   = ramload;
        if (!iREN) begin
          next_state = IDLE;
        end else if (access) begin
          next_state  = IDLE;
          next_starve = '0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
